alt_vipvfr121_prc_packet_reader: RTL and testbench

ALT_VIPVFR121_PRC_PACKET_READER -- requirements
Module: alt_vipvfr121_prc_packet_reader

---
 rtl/alt_vipvfr121_prc_pkg.sv | 36 +++
 rtl/alt_vipvfr121_prc_regs.sv | 77 +++++++
 rtl/alt_vipvfr121_prc_packet_reader.sv | 129 ++++++++++++
 tb/tb_alt_vipvfr121_prc_packet_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipvfr121_prc_pkg.sv
// Shared definitions for the packet reader: register map, control bit positions,
// engine state encoding and the packet configuration payload.
package alt_vipvfr121_prc_pkg;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned TYPE_W = 4;

  localparam logic [REG_AW-1:0] REG_GO        = 3'd0;
  localparam logic [REG_AW-1:0] REG_STATUS    = 3'd1;
  localparam logic [REG_AW-1:0] REG_INTERRUPT = 3'd2;
  localparam logic [REG_AW-1:0] REG_ADDRESS   = 3'd3;
  localparam logic [REG_AW-1:0] REG_TYPE      = 3'd4;
  localparam logic [REG_AW-1:0] REG_SAMPLES   = 3'd5;
  localparam logic [REG_AW-1:0] REG_WORDS     = 3'd6;

  localparam int unsigned GO_BIT      = 0;
  localparam int unsigned IRQ_EN_BIT  = 1;
  localparam int unsigned RUNNING_BIT = 0;
  localparam int unsigned EOP_BIT     = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_TYPE = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_SEND_DATA = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  typedef struct packed {
    logic [31:0]       address;
    logic [TYPE_W-1:0] ptype;
    logic [31:0]       words;
  } pkt_cfg_t;

endpackage

// File: rtl/alt_vipvfr121_prc_regs.sv
// Avalon-MM register file: control/status bits, packet configuration and readback.
module alt_vipvfr121_prc_regs
  import alt_vipvfr121_prc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] slave_address,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              start,
  input  logic              done,
  output logic              go,
  output logic              irq_enable,
  output logic              eop_pending,
  output pkt_cfg_t          cfg
);

  logic        running;
  logic [31:0] samples;
  logic [31:0] rd_mux_c;

  // Readback mux; unused bits and address 7 read as zero
  always_comb begin
    rd_mux_c = '0;
    case (slave_address)
      REG_GO: begin
        rd_mux_c[GO_BIT]     = go;
        rd_mux_c[IRQ_EN_BIT] = irq_enable;
      end
      REG_STATUS:    rd_mux_c[RUNNING_BIT] = running;
      REG_INTERRUPT: rd_mux_c[EOP_BIT]     = eop_pending;
      REG_ADDRESS:   rd_mux_c              = cfg.address;
      REG_TYPE:      rd_mux_c[TYPE_W-1:0]  = cfg.ptype;
      REG_SAMPLES:   rd_mux_c              = samples;
      REG_WORDS:     rd_mux_c              = cfg.words;
      default:       rd_mux_c              = '0;
    endcase
  end

  // Engine events are applied last so a DONE set beats a coincident clear write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slave_readdata <= '0;
      go             <= 1'b0;
      irq_enable     <= 1'b0;
      eop_pending    <= 1'b0;
      running        <= 1'b0;
      samples        <= '0;
      cfg            <= '0;
    end else begin
      if (slave_read) slave_readdata <= rd_mux_c;
      if (start) running <= 1'b1;
      if (slave_write) begin
        case (slave_address)
          REG_GO: begin
            irq_enable <= slave_writedata[IRQ_EN_BIT];
            if (!running) go <= slave_writedata[GO_BIT];
          end
          REG_INTERRUPT: if (slave_writedata[EOP_BIT]) eop_pending <= 1'b0;
          REG_ADDRESS:   cfg.address <= slave_writedata;
          REG_TYPE:      cfg.ptype   <= slave_writedata[TYPE_W-1:0];
          REG_SAMPLES:   samples     <= slave_writedata;
          REG_WORDS:     cfg.words   <= slave_writedata;
          default: ;
        endcase
      end
      if (done) begin
        go          <= 1'b0;
        running     <= 1'b0;
        eop_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alt_vipvfr121_prc_packet_reader.sv
// Packet reader: fetches WORDS words from memory via a read master and emits them
// as one Avalon-ST packet headed by a TYPE beat.
module alt_vipvfr121_prc_packet_reader
  import alt_vipvfr121_prc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_AW-1:0]     slave_address,
  input  logic                  slave_write,
  input  logic [31:0]           slave_writedata,
  input  logic                  slave_read,
  output logic [31:0]           slave_readdata,
  output logic                  slave_irq,
  output logic [ADDR_WIDTH-1:0] rm_address,
  output logic                  rm_read,
  input  logic                  rm_waitrequest,
  input  logic [DATA_WIDTH-1:0] rm_readdata,
  input  logic                  rm_readdatavalid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket
);

  state_t                state;
  pkt_cfg_t              cfg;
  logic                  go;
  logic                  irq_enable;
  logic                  eop_pending;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_words;
  logic [31:0]           count;
  logic [31:0]           count_inc_c;
  logic                  last_c;
  logic                  start_c;
  logic                  done_c;

  assign start_c     = (state == ST_IDLE) && go;
  assign done_c      = (state == ST_DONE);
  assign count_inc_c = count + 32'd1;
  assign last_c      = (count == lat_words - 32'd1);
  assign slave_irq   = eop_pending & irq_enable;

  alt_vipvfr121_prc_regs u_regs (
    .clock           (clock),
    .reset_n         (reset_n),
    .slave_address   (slave_address),
    .slave_write     (slave_write),
    .slave_writedata (slave_writedata),
    .slave_read      (slave_read),
    .slave_readdata  (slave_readdata),
    .start           (start_c),
    .done            (done_c),
    .go              (go),
    .irq_enable      (irq_enable),
    .eop_pending     (eop_pending),
    .cfg             (cfg)
  );

  // Engine: outputs are loaded on entry to the state that presents them
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      lat_addr           <= '0;
      lat_words          <= '0;
      count              <= '0;
      rm_read            <= 1'b0;
      rm_address         <= '0;
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          lat_addr           <= ADDR_WIDTH'(cfg.address);
          lat_words          <= cfg.words;
          count              <= '0;
          dout_valid         <= 1'b1;
          dout_startofpacket <= 1'b1;
          dout_endofpacket   <= (cfg.words == 32'd0);
          dout_data          <= DATA_WIDTH'(cfg.ptype);
          state              <= ST_SEND_TYPE;
        end
        ST_SEND_TYPE: if (dout_ready) begin
          dout_valid         <= 1'b0;
          dout_startofpacket <= 1'b0;
          dout_endofpacket   <= 1'b0;
          if (lat_words == 32'd0) begin
            state <= ST_DONE;
          end else begin
            rm_read    <= 1'b1;
            rm_address <= lat_addr;
            state      <= ST_READ_REQ;
          end
        end
        ST_READ_REQ: if (!rm_waitrequest) begin
          rm_read <= 1'b0;
          state   <= ST_READ_WAIT;
        end
        ST_READ_WAIT: if (rm_readdatavalid) begin
          dout_valid       <= 1'b1;
          dout_data        <= rm_readdata;
          dout_endofpacket <= last_c;
          state            <= ST_SEND_DATA;
        end
        ST_SEND_DATA: if (dout_ready) begin
          dout_valid       <= 1'b0;
          dout_endofpacket <= 1'b0;
          count            <= count_inc_c;
          if (last_c) begin
            state <= ST_DONE;
          end else begin
            rm_read    <= 1'b1;
            rm_address <= lat_addr + ADDR_WIDTH'({count_inc_c, 2'b00});
            state      <= ST_READ_REQ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alt_vipvfr121_prc_packet_reader.sv
// Self-checking bench for the packet reader: register table, directed packets,
// randomized packets against a queue-based packet model, reset and DONE corners.
module tb_alt_vipvfr121_prc_packet_reader;
  import alt_vipvfr121_prc_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [2:0]  slave_address;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_irq;
  logic [31:0] rm_address;
  logic        rm_read;
  logic        rm_waitrequest;
  logic [31:0] rm_readdata;
  logic        rm_readdatavalid;
  logic [31:0] dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_startofpacket;
  logic        dout_endofpacket;

  alt_vipvfr121_prc_packet_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .slave_address(slave_address), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_irq(slave_irq),
    .rm_address(rm_address), .rm_read(rm_read), .rm_waitrequest(rm_waitrequest),
    .rm_readdata(rm_readdata), .rm_readdatavalid(rm_readdatavalid),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;

  // Environment state: memory image, response pipe, backpressure knobs
  logic [31:0] mem [logic [31:0]];
  logic [33:0] exp_beats[$], got_beats[$];
  logic [31:0] exp_rd[$], got_rd[$];
  int          ready_pct = 100, wait_pct = 0, stall_left = 0, rsp_cnt = 0;
  logic [31:0] rsp_addr;
  bit          prev_hold = 0, prev_rd_wait = 0;
  logic [34:0] prev_beat;
  logic [31:0] prev_rd_addr;
  logic [31:0] m_addr = '0, m_words = '0;
  logic [3:0]  m_type = '0;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // One cycle: advance to negedge, check held outputs, pick inputs for the next edge
  task automatic tick();
    @(negedge clock);
    if (prev_hold)
      check("dout_hold", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, prev_beat);
    if (prev_rd_wait)
      check("rm_hold", {rm_read, rm_address}, {1'b1, prev_rd_addr});
    rm_readdatavalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rm_readdatavalid = 1'b1;
        rm_readdata      = mem_rd(rsp_addr);
      end
    end
    if (rm_read && stall_left > 0) begin
      rm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      rm_waitrequest = ($urandom_range(99) < 32'(wait_pct));
    end
    if (rm_read && !rm_waitrequest) begin
      got_rd.push_back(rm_address);
      rsp_addr = rm_address;
      rsp_cnt  = 1 + int'($urandom_range(3));
    end
    dout_ready = ($urandom_range(99) < 32'(ready_pct));
    if (dout_valid && dout_ready)
      got_beats.push_back({dout_startofpacket, dout_endofpacket, dout_data});
    prev_hold    = dout_valid && !dout_ready;
    prev_beat    = {dout_valid, dout_startofpacket, dout_endofpacket, dout_data};
    prev_rd_wait = rm_read && rm_waitrequest;
    prev_rd_addr = rm_address;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    tick();
    slave_write = 1'b0;
    case (a)
      REG_ADDRESS: m_addr = d;
      REG_TYPE:    m_type = d[3:0];
      REG_WORDS:   m_words = d;
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    slave_address = a; slave_read = 1'b1;
    tick();
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  // Packet model: TYPE header beat, then one beat per word at address + 4*i
  task automatic start_go(input logic [31:0] goval);
    exp_beats.delete(); got_beats.delete(); exp_rd.delete(); got_rd.delete();
    exp_beats.push_back({1'b1, m_words == 0, 28'h0, m_type});
    for (int i = 0; i < int'(m_words); i++) begin
      logic [31:0] a;
      a = m_addr + 32'(i) * 32'd4;
      exp_rd.push_back(a);
      exp_beats.push_back({1'b0, i == int'(m_words) - 1, mem_rd(a)});
    end
    reg_write(REG_GO, goval);
  endtask

  task automatic start_packet(input logic [31:0] a, input logic [31:0] t,
                              input logic [31:0] w, input logic [31:0] goval);
    reg_write(REG_ADDRESS, a);
    reg_write(REG_TYPE, t);
    reg_write(REG_WORDS, w);
    start_go(goval);
  endtask

  task automatic finish_packet(input logic exp_irq);
    int n = 0;
    logic [31:0] rd;
    while (got_beats.size() < exp_beats.size() && n < 3000) begin
      tick();
      n++;
    end
    check("pkt_timeout", n < 3000, 1);
    repeat (4) tick();
    check("beat_count", got_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
      check($sformatf("beat%0d", i), got_beats[i], exp_beats[i]);
    check("read_count", got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      check($sformatf("rd_addr%0d", i), got_rd[i], exp_rd[i]);
    reg_read(REG_STATUS, rd);
    check("status_idle", rd, 0);
    reg_read(REG_INTERRUPT, rd);
    check("eop_pending", rd, 2);
    check("irq", slave_irq, exp_irq);
    reg_write(REG_INTERRUPT, 32'h2);
    tick();
    check("irq_cleared", slave_irq, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    vecs[0] = '{REG_ADDRESS, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{REG_TYPE,    32'hFFFF_FFF7, 32'h0000_0007};
    vecs[2] = '{REG_SAMPLES, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{REG_WORDS,   32'h0000_0005, 32'h0000_0005};
    vecs[4] = '{3'd7,        32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{REG_STATUS,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{REG_GO,      32'h0000_0002, 32'h0000_0002};
    vecs[7] = '{REG_INTERRUPT, 32'h0000_0002, 32'h0000_0000};

    slave_address = '0; slave_write = 0; slave_writedata = '0; slave_read = 0;
    rm_waitrequest = 0; rm_readdata = '0; rm_readdatavalid = 0; dout_ready = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) tick();
    check("rst_stream", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, 0);
    check("rst_slave_rm", {slave_irq, slave_readdata, rm_read, rm_address}, 0);
    reset_n = 1'b1;
    tick();

    // Register map readback
    for (int i = 0; i < 8; i++) begin
      reg_write(vecs[i].a, vecs[i].wd);
      reg_read(vecs[i].a, rd);
      check($sformatf("reg%0d", vecs[i].a), rd, vecs[i].exp);
    end

    // Three-word packet with known memory contents, irq enabled
    mem[32'h1000] = 32'hA; mem[32'h1004] = 32'hB; mem[32'h1008] = 32'hC;
    ready_pct = 100; wait_pct = 0;
    start_packet(32'h1000, 0, 3, 3);
    finish_packet(1'b1);

    // Header-only packet, irq disabled
    start_packet(32'h2000, 32'hF, 0, 1);
    finish_packet(1'b0);

    // Stalled read master plus backpressure; GO write while running only sets irq_enable
    stall_left = 5; ready_pct = 50;
    start_packet(32'h4000, 3, 3, 1);
    repeat (3) tick();
    reg_write(REG_GO, 32'h2);
    reg_read(REG_GO, rd);
    check("go_while_running", rd, 3);
    finish_packet(1'b1);

    // Mid-packet WORDS write affects only the next packet
    ready_pct = 100;
    start_packet(32'h5000, 2, 2, 1);
    repeat (4) tick();
    reg_write(REG_WORDS, 8);
    finish_packet(1'b0);
    start_go(1);
    finish_packet(1'b0);

    // Randomized packets, first one straddles the address wrap
    for (int p = 0; p < 8; p++) begin
      logic [31:0] a;
      a = (p == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      ready_pct = int'($urandom_range(30, 100));
      wait_pct  = int'($urandom_range(0, 60));
      rd = 32'h1 | (32'($urandom_range(1)) << 1);
      start_packet(a, $urandom_range(15), $urandom_range(6), rd);
      finish_packet(rd[1]);
    end

    // Clear write landing in the DONE cycle loses to the set
    ready_pct = 100; wait_pct = 0;
    start_packet(32'h6000, 1, 1, 3);
    n = 0;
    while (!(dout_valid && dout_endofpacket) && n < 200) begin tick(); n++; end
    check("done_wait", n < 200, 1);
    tick();
    slave_address = REG_INTERRUPT; slave_writedata = 32'h2; slave_write = 1'b1;
    tick();
    slave_write = 1'b0;
    finish_packet(1'b1);

    // Asynchronous reset while a data beat is presented
    start_packet(32'h7000, 5, 4, 3);
    n = 0;
    while (!(dout_valid && !dout_startofpacket) && n < 200) begin tick(); n++; end
    check("send_data_wait", n < 200, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_stream", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, 0);
    check("rst_mid_slave_rm", {slave_irq, slave_readdata, rm_read, rm_address}, 0);
    prev_hold = 0; prev_rd_wait = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    m_addr = '0; m_type = '0; m_words = '0;
    got_beats.delete(); got_rd.delete();
    repeat (4) tick();
    check("no_beat_after_reset", got_beats.size(), 0);
    reg_read(REG_GO, rd);
    check("go_after_reset", rd, 0);
    reg_read(REG_ADDRESS, rd);
    check("addr_after_reset", rd, 0);
    start_packet(32'h3000, 2, 3, 1);
    finish_packet(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
